// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if
//   Bundles the SPI register-bank configuration and the pin-side results of
//   pwm_peripheral into one interface.
//   master : register bank / top level (drives config, observes outputs)
//   slave  : pwm_peripheral (consumes config, drives out/period_start)
//   Signals:
//     en_reg_out_7_0/15_8   per-pin output enable
//     en_reg_pwm_7_0/15_8   per-pin PWM select
//     pwm_duty_cycle        duty in 1/256 units (255 = constant high)
//     out[15:0]             pin drive, 7:0 -> uo_out, 15:8 -> uio_out
//     period_start          one-clk pulse when the PWM counter wraps to 0
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8,
        output en_reg_pwm_7_0, en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out, period_start
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8,
        input  en_reg_pwm_7_0, en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out, period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Re-times the SPI register configuration into clk through a synchroniser
//   and a two-sample stability filter, then drives 16 pins that are each
//   forced low, forced high, or driven by one shared 8-bit PWM waveform.
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-low reset
//     bus  pwm_peripheral_if.slave (config in, out[15:0]/period_start out)
//   Parameters:
//     PRESCALE     clk cycles per PWM tick (1..65535)
//     SYNC_STAGES  synchroniser depth for configuration (2..3)
//   Build option:
//     PWM_SHADOW_EN  when defined, duty is latched into a shadow register at
//                    each PWM wrap so a duty change never truncates a period.

// One output pin: low when disabled, high when enabled without PWM,
// otherwise follows the shared PWM level. Registered.
module pwm_pin (
    input  logic clk,
    input  logic rst,
    input  logic en_out,
    input  logic en_pwm,
    input  logic pwm,
    output logic out_q
);
    logic out_d;

    always_comb begin
        out_d = en_out & (~en_pwm | pwm);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_q <= 1'b0;
        else      out_q <= out_d;
    end
endmodule

module pwm_peripheral #(
    parameter int unsigned PRESCALE    = 3000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_PINS    = 16
) (
    input  logic                clk,
    input  logic                rst,
    pwm_peripheral_if.slave     bus
);
    typedef struct packed {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  duty;
    } cfg_t;

    localparam int unsigned CFG_W     = $bits(cfg_t);
    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    cfg_t                              bundle_in;
    logic [SYNC_STAGES-1:0][CFG_W-1:0] sync_q, sync_d;
    cfg_t                              cfg_q, cfg_d;
    logic                              stable;

    logic [15:0] presc_q, presc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic        period_start_q, period_start_d;
    logic        tick, wrap;
    logic [7:0]  duty_eff;
    logic        pwm;

    assign bundle_in = {bus.en_reg_out_15_8, bus.en_reg_out_7_0,
                        bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0,
                        bus.pwm_duty_cycle};

    // Synchroniser shift plus stability filter. The last stage is accepted
    // only when it matches the stage behind it, i.e. the synchronised value
    // is about to repeat; this keeps input-to-config latency at
    // SYNC_STAGES+1 clk and holds the old config while the bus is moving.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bundle_in};
        stable = (sync_q[SYNC_STAGES-1] == sync_q[SYNC_STAGES-2]);
        cfg_d  = stable ? cfg_t'(sync_q[SYNC_STAGES-1]) : cfg_q;
    end

    // Prescaler and PWM counter.
    always_comb begin
        tick           = (presc_q == PRESC_MAX);
        presc_d        = tick ? 16'd0 : presc_q + 16'd1;
        pcnt_d         = tick ? pcnt_q + 8'd1 : pcnt_q;
        wrap           = tick && (pcnt_q == 8'hFF);
        period_start_d = wrap;
    end

`ifdef PWM_SHADOW_EN
    // Shadow duty loads on the same edge that takes pcnt 255->0, so the
    // whole new period (starting at pcnt=0) is compared against one value.
    logic [7:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = wrap ? cfg_q.duty : shadow_q;
        duty_eff = shadow_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) shadow_q <= 8'h00;
        else      shadow_q <= shadow_d;
    end
`else
    always_comb begin
        duty_eff = cfg_q.duty;
    end
`endif

    // 255 is forced high so the pcnt==255 slot does not drop low at wrap.
    always_comb begin
        pwm = (duty_eff == 8'hFF) || ((duty_eff != 8'h00) && (pcnt_q < duty_eff));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q         <= '0;
            cfg_q          <= '0;
            presc_q        <= 16'd0;
            pcnt_q         <= 8'd0;
            period_start_q <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            cfg_q          <= cfg_d;
            presc_q        <= presc_d;
            pcnt_q         <= pcnt_d;
            period_start_q <= period_start_d;
        end
    end

    logic [NUM_PINS-1:0] out_w;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        pwm_pin u_pin (
            .clk    (clk),
            .rst    (rst),
            .en_out (cfg_q.en_out[i]),
            .en_pwm (cfg_q.en_pwm[i]),
            .pwm    (pwm),
            .out_q  (out_w[i])
        );
    end

    assign bus.out          = out_w;
    assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral
//   Directed bench for pwm_peripheral with PRESCALE=4, SYNC_STAGES=2
//   (PWM period = 1024 clk). Outputs are sampled on the falling edge.
//   Expected values are hand-derived; the PWM_SHADOW_EN build selects the
//   shadow-duty expectations for the mid-period duty change.
module tb_pwm_peripheral;
    localparam int P   = 4;
    localparam int S   = 2;
    localparam int PER = 256 * P;

`ifdef PWM_SHADOW_EN
    localparam int STEP_HI   = 256;  // current period keeps duty 0x40
    localparam int STEP_OUT  = 0;    // change not visible mid-period
`else
    localparam int STEP_HI   = 621;  // 256 + (768 - 403) high clk
    localparam int STEP_OUT  = 1;    // change visible S+2 clk after input
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_peripheral_if bus();

    pwm_peripheral #(.PRESCALE(P), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        bus.en_reg_out_7_0  = eo[7:0];
        bus.en_reg_out_15_8 = eo[15:8];
        bus.en_reg_pwm_7_0  = ep[7:0];
        bus.en_reg_pwm_15_8 = ep[15:8];
        bus.pwm_duty_cycle  = d;
    endtask

    int          hi0, nps;
    logic [15:0] and_acc, or_acc;

    // Observe n consecutive cycles.
    task automatic window(input int n);
        hi0 = 0; nps = 0; and_acc = 16'hFFFF; or_acc = 16'h0000;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            hi0     += int'(bus.out[0]);
            nps     += int'(bus.period_start);
            and_acc &= bus.out;
            or_acc  |= bus.out;
        end
    endtask

    // Edges until period_start is seen; max+1 if it never comes.
    task automatic wait_ps(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n <= max);
    endtask

    // Release reset (config must be en_out=FFFF, en_pwm=0) and check config
    // latency and first period_start position.
    task automatic release_chk(input string tag);
        int first;
        first = 0;
        rst = 1'b1;
        for (int k = 1; k <= PER + 80; k++) begin
            @(negedge clk);
            if (k == S + 1) chk({tag, "_out_early"}, bus.out, 16'h0000);
            if (k == S + 2) chk({tag, "_out_on"}, bus.out, 16'hFFFF);
            if (bus.period_start && first == 0) first = k;
            if (first != 0) break;
        end
        chk({tag, "_first_ps"}, first, PER);
    endtask

    initial begin
        int n;
        int tg;

        // reset
        set_cfg(16'hFFFF, 16'h0000, 8'h00);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", bus.out, 16'h0000);
        chk("rst_ps", bus.period_start, 1'b0);

        // all pins forced high
        release_chk("boot");
        window(PER);
        chk("high_nps", nps, 1);
        chk("high_and", and_acc, 16'hFFFF);

        // half duty on low byte, high byte disabled
        set_cfg(16'h00FF, 16'h00FF, 8'h80);
        wait_ps(PER + 10, n);
        chk("ps_gap", n, PER);
        window(PER);
        chk("half_hi0", hi0, PER / 2);
        chk("half_hibyte", or_acc[15:8], 8'h00);
        chk("half_nps", nps, 1);

        // duty 0 then 255 across three periods each
        set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
        wait_ps(PER + 10, n);
        window(3 * PER);
        chk("duty0_or", or_acc, 16'h0000);
        chk("duty0_nps", nps, 3);
        set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_ps(PER + 10, n);
        window(3 * PER);
        chk("duty255_and", and_acc, 16'hFFFF);

        // duty 0x40 -> 0xC0 mid-period
        set_cfg(16'hFFFF, 16'hFFFF, 8'h40);
        wait_ps(PER + 10, n);
        wait_ps(PER + 10, n);
        chk("step_align", n, PER);
        hi0 = 0;
        for (int j = 1; j <= PER; j++) begin
            @(negedge clk);
            hi0 += int'(bus.out[0]);
            if (j == 403)       chk("step_pre", bus.out[0], 1'b0);
            if (j == 400 + S + 2) chk("step_post", bus.out[0], STEP_OUT);
            if (j == 400) bus.pwm_duty_cycle = 8'hC0;
        end
        chk("step_w1_hi", hi0, STEP_HI);
        window(PER);
        chk("step_w2_hi", hi0, 192 * P);

        // toggling input is filtered, then accepted after hold
        set_cfg(16'hFFFF, 16'h0000, 8'hC0);
        repeat (6) @(negedge clk);
        chk("tog_pre", bus.out, 16'hFFFF);
        tg = 1;
        for (int k = 0; k < 10; k++) begin
            bus.en_reg_out_7_0[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            tg &= int'(bus.out[0]);
        end
        bus.en_reg_out_7_0[0] = 1'b0;
        repeat (S + 1) begin
            @(negedge clk);
            tg &= int'(bus.out[0]);
        end
        chk("tog_held", tg, 1);
        @(negedge clk);
        chk("tog_accept", bus.out[0], 1'b0);

        // asynchronous reset mid-period
        set_cfg(16'hFFFF, 16'h0000, 8'hC0);
        repeat (6) @(negedge clk);
        chk("mid_pre", bus.out, 16'hFFFF);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out", bus.out, 16'h0000);
        chk("mid_rst_ps", bus.period_start, 1'b0);
        repeat (3) @(negedge clk);
        release_chk("rerun");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
